// File: rtl/ci_cdc_arb_pkg.sv
// Shared definitions for the ci_cdc_arb CDC-channel scheduler:
// FSM state encoding and default sizing constants.
package ci_cdc_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int IDW_DEF   = 2;
  localparam int TMO_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/ci_rr_pick.sv
// Grant selector for ci_cdc_arb.
// Default build: round-robin, first pending bit at or after last+1 (mod NREQ).
// With CI_CDC_ARB_PRIO_EN defined: fixed priority, lowest pending index wins,
// and the last-grant input is ignored.
module ci_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_pend,
  input  logic [IDW-1:0]  i_last,
  output logic [IDW-1:0]  o_id,
  output logic            o_vld
);

  assign o_vld = |i_pend;

`ifdef CI_CDC_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = ^i_last;

  // Lowest set index wins; scan downward so the smallest index is written last.
  always_comb begin
    o_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_pend[i]) o_id = IDW'(i);
    end
  end
`else
  // Scan offsets from farthest to nearest so the nearest pending bit after
  // the last grant is the one that survives.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    idx   = 0;
    idx_w = '0;
    o_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(i_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (i_pend[idx_w]) o_id = idx_w;
    end
  end
`endif

endmodule

// File: rtl/ci_cdc_arb.sv
// ci_cdc_arb: master-domain scheduler sharing one enable/ready CDC pulse
// channel between NREQ requesters. Requests are latched into a pending
// vector, one owner is granted at a time, a one-cycle enable is issued on an
// i_ena tick, and the owner gets a done pulse on ready or an error pulse on
// timeout. Grant policy is round-robin unless CI_CDC_ARB_PRIO_EN is defined,
// which selects fixed priority (lowest index first).
module ci_cdc_arb
  import ci_cdc_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = IDW_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             i_mclk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic [NREQ-1:0]  i_req,
  input  logic [TMO_W-1:0] i_tmo,
  input  logic             i_rdy,
  output logic             o_men,
  output logic [IDW-1:0]   o_ch_id,
  output logic             o_busy,
  output logic [NREQ-1:0]  o_done,
  output logic [NREQ-1:0]  o_err,
  output logic [NREQ-1:0]  o_pend
);

  localparam logic [NREQ-1:0] OH_BASE   = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);
  localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [NREQ-1:0]  pend_q,  pend_d;
  logic [IDW-1:0]   ch_id_q, ch_id_d;
  logic [IDW-1:0]   last_q,  last_d;
  logic [TMO_W-1:0] cnt_q,   cnt_d;

  logic [NREQ-1:0]  owner_oh;
  logic [NREQ-1:0]  clr;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  err;
  logic             men;
  logic [IDW-1:0]   pick_id;
  logic             pick_vld;

  ci_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_pend (pend_q),
    .i_last (last_q),
    .o_id   (pick_id),
    .o_vld  (pick_vld)
  );

  assign owner_oh = OH_BASE << ch_id_q;

  // Next-state, issue/completion pulses and pending-vector update.
  always_comb begin
    state_d = state_q;
    ch_id_d = ch_id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    men     = 1'b0;
    done    = '0;
    err     = '0;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          ch_id_d = pick_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_ena) begin
          men     = 1'b1;
          cnt_d   = i_tmo;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ready beats timeout; cnt only reaches 1 when a nonzero timeout
        // was loaded, so a zero timeout never expires.
        if (i_rdy) begin
          done    = owner_oh;
          clr     = owner_oh;
          last_d  = ch_id_q;
          state_d = GAP;
        end else if (i_ena && (cnt_q == CNT_ONE)) begin
          err     = owner_oh;
          clr     = owner_oh;
          last_d  = ch_id_q;
          state_d = GAP;
        end else if (i_ena && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new request wins over the clear of the same bit.
    pend_d = (pend_q & ~clr) | i_req;
  end

  // State, pending vector, owner, last-grant pointer and timeout counter.
  always_ff @(posedge i_mclk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ch_id_q <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ch_id_q <= ch_id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses are suppressed in a reset cycle so an aborted transfer reports nothing.
  assign o_men   = men & ~i_rst;
  assign o_done  = done & {NREQ{~i_rst}};
  assign o_err   = err & {NREQ{~i_rst}};
  assign o_ch_id = ch_id_q;
  assign o_busy  = (state_q != IDLE);
  assign o_pend  = pend_q;

endmodule

// File: tb/tb_ci_cdc_arb.sv
// Directed testbench for ci_cdc_arb (NREQ=4, IDW=2, TMO_W=8).
module tb_ci_cdc_arb;

  logic       i_mclk = 1'b0;
  logic       i_rst  = 1'b1;
  logic       i_ena  = 1'b0;
  logic [3:0] i_req  = '0;
  logic [7:0] i_tmo  = '0;
  logic       i_rdy  = 1'b0;
  logic       o_men;
  logic [1:0] o_ch_id;
  logic       o_busy;
  logic [3:0] o_done;
  logic [3:0] o_err;
  logic [3:0] o_pend;

  int n_chk  = 0;
  int n_fail = 0;

  ci_cdc_arb #(.NREQ(4), .IDW(2), .TMO_W(8)) dut (
    .i_mclk  (i_mclk),
    .i_rst   (i_rst),
    .i_ena   (i_ena),
    .i_req   (i_req),
    .i_tmo   (i_tmo),
    .i_rdy   (i_rdy),
    .o_men   (o_men),
    .o_ch_id (o_ch_id),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_pend  (o_pend)
  );

  always #5 i_mclk = ~i_mclk;

  // One clock cycle: inputs change 1 time unit after the edge, checks follow 2 units later.
  task automatic step(input logic [3:0] req, input logic rdy, input logic ena,
                      input logic rst = 1'b0);
    @(posedge i_mclk);
    #1;
    i_req = req;
    i_rdy = rdy;
    i_ena = ena;
    i_rst = rst;
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starting in an IDLE cycle with exp_id pending and a grant available:
  // pick, issue, immediate ready, gap.
  task automatic serve(input int exp_id);
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    step(4'b0000, 1'b0, 1'b1);
    chk("serve_idle_busy", o_busy, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("serve_men", o_men, 1);
    chk("serve_ch_id", o_ch_id, exp_id);
    step(4'b0000, 1'b1, 1'b1);
    chk("serve_done", o_done, oh);
    chk("serve_no_err", o_err, 0);
    step(4'b0000, 1'b1, 1'b1);
    chk("serve_gap_busy", o_busy, 1);
    chk("serve_gap_no_done", o_done, 0);
  endtask

  initial begin
    // Reset values
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("rst_busy", o_busy, 0);
    chk("rst_pend", o_pend, 0);
    chk("rst_ch_id", o_ch_id, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("rst_men", o_men, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);

    // Round-robin burst from reset pointer (last=3): 0,1,3
    step(4'b1011, 1'b0, 1'b1);
    chk("rr_pend_before", o_pend, 0);
    serve(0);
    chk("rr_pend_after0", o_pend, 4'b1010);
    serve(1);
    serve(3);
    chk("rr_pend_empty", o_pend, 0);
    // Second burst: last=3 wraps to 0
    step(4'b1011, 1'b0, 1'b1);
    serve(0);
    serve(1);
    serve(3);

    // Single request, ready 6 cycles after the enable
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("single_pend", o_pend, 4'b0100);
    chk("single_idle", o_busy, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("single_men", o_men, 1);
    chk("single_ch_id", o_ch_id, 2);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b0, 1'b1);
      chk("single_wait_men", o_men, 0);
      chk("single_wait_done", o_done, 0);
    end
    step(4'b0000, 1'b1, 1'b1);
    chk("single_done", o_done, 4'b0100);
    step(4'b0000, 1'b0, 1'b1);
    chk("single_gap_busy", o_busy, 1);
    chk("single_pend_clr", o_pend, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("single_busy_low", o_busy, 0);

    // Timeout of 5 ticks (last=2, so requester 0 is granted)
    i_tmo = 8'd5;
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("tmo_men", o_men, 1);
    chk("tmo_ch_id", o_ch_id, 0);
    for (int i = 1; i <= 4; i++) begin
      step(4'b0000, 1'b0, 1'b1);
      chk("tmo_early_err", o_err, 0);
    end
    step(4'b0000, 1'b0, 1'b1);
    chk("tmo_err", o_err, 4'b0001);
    chk("tmo_no_done", o_done, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("tmo_gap_err", o_err, 0);
    chk("tmo_pend_clr", o_pend, 0);

    // Zero timeout waits indefinitely, then collision of ready with re-request
    i_tmo = 8'd0;
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("notmo_men", o_men, 1);
    chk("notmo_ch_id", o_ch_id, 1);
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b0, 1'b1);
      chk("notmo_no_err", o_err, 0);
    end
    chk("notmo_busy", o_busy, 1);
    step(4'b0010, 1'b1, 1'b1);
    chk("coll_done", o_done, 4'b0010);
    step(4'b0000, 1'b0, 1'b1);
    chk("coll_pend_kept", o_pend, 4'b0010);
    serve(1);
    chk("coll_pend_clr", o_pend, 0);

    // Stray ready in IDLE
    step(4'b0000, 1'b1, 1'b1);
    chk("stray_done", o_done, 0);
    chk("stray_busy", o_busy, 0);

    // Reset in the middle of WAIT, with a ready and a request in the reset cycle
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("abort_men", o_men, 1);
    chk("abort_ch_id", o_ch_id, 2);
    step(4'b0000, 1'b0, 1'b1);
    chk("abort_wait_busy", o_busy, 1);
    step(4'b0001, 1'b1, 1'b1, 1'b1);
    chk("abort_rst_done", o_done, 0);
    step(4'b0000, 1'b1, 1'b1);
    chk("abort_busy", o_busy, 0);
    chk("abort_pend", o_pend, 0);
    chk("abort_ch_id0", o_ch_id, 0);
    chk("abort_late_done", o_done, 0);
    chk("abort_men0", o_men, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("abort_idle", o_busy, 0);

    // i_ena one cycle in four: issue waits for a tick, timeout counts ticks
    i_tmo = 8'd3;
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("ena_issue_hold", o_men, 0);
    chk("ena_issue_busy", o_busy, 1);
    step(4'b0000, 1'b0, 1'b0);
    chk("ena_issue_hold2", o_men, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("ena_men", o_men, 1);
    chk("ena_ch_id", o_ch_id, 0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        step(4'b0000, 1'b0, 1'b0);
        chk("ena_off_err", o_err, 0);
      end
      step(4'b0000, 1'b0, 1'b1);
      if (r < 2) chk("ena_tick_err", o_err, 0);
      else       chk("ena_tmo_err", o_err, 4'b0001);
    end
    step(4'b0000, 1'b0, 1'b1);
    chk("ena_gap_pend", o_pend, 0);

    // Two requesters 1 and 3: granted 1 then 3
    step(4'b1010, 1'b0, 1'b1);
    serve(1);
    chk("pair_pend", o_pend, 4'b1000);
    serve(3);
    chk("pair_pend_clr", o_pend, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
